// File: rtl/arb4_pkg.sv
// Shared types and constants for the four-way grant controller.
package arb4_pkg;

    localparam int NREQ       = 4;
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_e;

endpackage

// File: rtl/rot_prio_enc4.sv
// Rotating 4-bit priority encoder: rotate, pick highest set bit,
// un-rotate the winning index.
module rot_prio_enc4
    import arb4_pkg::*;
(
    input  logic [NREQ-1:0] d,
    input  logic [1:0]      rot,
    output logic [1:0]      out,
    output logic            valid
);

    logic [NREQ-1:0] r;
    logic [1:0]      p;
    logic [1:0]      idx;

    // Rotated bit 3 holds d[rot-1], so the search starts just below rot.
    always_comb begin
        r   = '0;
        idx = '0;
        for (int j = 0; j < NREQ; j++) begin
            idx  = 2'(j) + rot;
            r[j] = d[idx];
        end
    end

    always_comb begin
        p = 2'd0;
        priority case (1'b1)
            r[3]:    p = 2'd3;
            r[2]:    p = 2'd2;
            r[1]:    p = 2'd1;
            r[0]:    p = 2'd0;
            default: p = 2'd0;
        endcase
    end

    assign out   = p + rot;
    assign valid = |d;

endmodule

// File: rtl/arb4_grant_ctrl.sv
// Four-requester arbiter with hold timeout and a dead cycle
// between owners.
module arb4_grant_ctrl
    import arb4_pkg::*;
#(
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      gnt_id,
    output logic            busy,
    output logic            preempt
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      last_q, last_d;
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      gnt_id_q, gnt_id_d;
    logic            preempt_q, preempt_d;

    logic [1:0] rot;
    logic [1:0] enc_out;
    logic       enc_valid;

    assign rot = (MODE == MODE_RR) ? last_q : 2'd0;

    rot_prio_enc4 u_enc (
        .d     (req),
        .rot   (rot),
        .out   (enc_out),
        .valid (enc_valid)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = '0;
        gnt_id_d   = '0;
        preempt_d  = 1'b0;
        unique case (state_q)
            IDLE, RELEASE: begin
                if (enc_valid) begin
                    state_d    = GRANT;
                    owner_d    = enc_out;
                    hold_cnt_d = '0;
                    gnt_d      = 4'b0001 << enc_out;
                    gnt_id_d   = enc_out;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
                // An owner dropping on its last cycle is a normal release.
                if (!req[owner_q]) begin
                    state_d = RELEASE;
                    last_d  = owner_q;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = RELEASE;
                    last_d    = owner_q;
                    preempt_d = 1'b1;
                end else begin
                    gnt_d    = gnt_q;
                    gnt_id_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_q     <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            preempt_q  <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = |gnt_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_arb4_grant_ctrl.sv
// Directed bench for arb4_grant_ctrl across fixed, round-robin
// and short-timeout configurations.
module tb_arb4_grant_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] rq   [0:3];
    logic [3:0] gn   [0:3];
    logic [1:0] gid  [0:3];
    logic       bsy  [0:3];
    logic       pre  [0:3];

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a: fixed/4, b: rr/4, c: fixed/2, d: rr/2
    arb4_grant_ctrl #(.MODE(0), .MAX_HOLD(4)) u_a (
        .clk(clk), .rst(rst), .req(rq[0]), .gnt(gn[0]),
        .gnt_id(gid[0]), .busy(bsy[0]), .preempt(pre[0])
    );
    arb4_grant_ctrl #(.MODE(1), .MAX_HOLD(4)) u_b (
        .clk(clk), .rst(rst), .req(rq[1]), .gnt(gn[1]),
        .gnt_id(gid[1]), .busy(bsy[1]), .preempt(pre[1])
    );
    arb4_grant_ctrl #(.MODE(0), .MAX_HOLD(2)) u_c (
        .clk(clk), .rst(rst), .req(rq[2]), .gnt(gn[2]),
        .gnt_id(gid[2]), .busy(bsy[2]), .preempt(pre[2])
    );
    arb4_grant_ctrl #(.MODE(1), .MAX_HOLD(2)) u_d (
        .clk(clk), .rst(rst), .req(rq[3]), .gnt(gn[3]),
        .gnt_id(gid[3]), .busy(bsy[3]), .preempt(pre[3])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) rq[i] = 4'b0000;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (gn[i] !== 4'b0000 || gid[i] !== 2'd0 ||
                bsy[i] !== 1'b0 || pre[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset dut%0d: gnt=%b id=%0d busy=%b pre=%b want 0",
                         i, gn[i], gid[i], bsy[i], pre[i]);
            end
        end
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (gn[i] !== 4'b0000 || bsy[i] !== 1'b0) begin
                bad++;
                $display("FAIL idle dut%0d: gnt=%b busy=%b want 0000/0",
                         i, gn[i], bsy[i]);
            end
        end
    endtask

    task automatic test_fixed();
        rq[0] = 4'b0110;
        step();
        total++;
        if (gn[0] !== 4'b0100 || gid[0] !== 2'd2 || bsy[0] !== 1'b1) begin
            bad++;
            $display("FAIL fixed_first: gnt=%b id=%0d busy=%b want 0100/2/1",
                     gn[0], gid[0], bsy[0]);
        end
        rq[0] = 4'b0010;
        step();
        total++;
        if (gn[0] !== 4'b0000 || bsy[0] !== 1'b0 || pre[0] !== 1'b0) begin
            bad++;
            $display("FAIL fixed_gap: gnt=%b busy=%b pre=%b want 0000/0/0",
                     gn[0], bsy[0], pre[0]);
        end
        step();
        total++;
        if (gn[0] !== 4'b0010 || gid[0] !== 2'd1) begin
            bad++;
            $display("FAIL fixed_second: gnt=%b id=%0d want 0010/1",
                     gn[0], gid[0]);
        end
        rq[0] = 4'b0000;
        step();
        step();
        total++;
        if (gn[0] !== 4'b0000 || gid[0] !== 2'd0) begin
            bad++;
            $display("FAIL fixed_idle: gnt=%b id=%0d want 0000/0",
                     gn[0], gid[0]);
        end
    endtask

    task automatic test_drop_timeout();
        logic [3:0] want;
        rq[0] = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            step();
            want = 4'b0001;
            total++;
            if (gn[0] !== want || pre[0] !== 1'b0) begin
                bad++;
                $display("FAIL hold_cyc%0d: gnt=%b pre=%b want %b/0",
                         c, gn[0], pre[0], want);
            end
        end
        rq[0] = 4'b0000;
        step();
        total++;
        if (gn[0] !== 4'b0000 || pre[0] !== 1'b0) begin
            bad++;
            $display("FAIL drop_at_timeout: gnt=%b pre=%b want 0000/0",
                     gn[0], pre[0]);
        end
        step();
    endtask

    task automatic test_round_robin();
        int         ids [5];
        logic [3:0] want;
        ids = '{3, 2, 1, 0, 3};
        rq[1] = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            want = 4'b0001 << ids[g];
            for (int c = 0; c < 4; c++) begin
                step();
                total++;
                if (gn[1] !== want || gid[1] !== 2'(ids[g]) ||
                    pre[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL rr_g%0d_c%0d: gnt=%b id=%0d pre=%b want %b/%0d/0",
                             g, c, gn[1], gid[1], pre[1], want, ids[g]);
                end
            end
            step();
            total++;
            if (gn[1] !== 4'b0000 || bsy[1] !== 1'b0 || pre[1] !== 1'b1) begin
                bad++;
                $display("FAIL rr_gap%0d: gnt=%b busy=%b pre=%b want 0000/0/1",
                         g, gn[1], bsy[1], pre[1]);
            end
        end
        rq[1] = 4'b0000;
        step();
        total++;
        if (gn[1] !== 4'b0000 || pre[1] !== 1'b0) begin
            bad++;
            $display("FAIL rr_idle: gnt=%b pre=%b want 0000/0",
                     gn[1], pre[1]);
        end
    endtask

    task automatic test_timeout_min();
        rq[2] = 4'b0001;
        rq[3] = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            step();
            for (int i = 2; i < 4; i++) begin
                total++;
                if (gn[i] !== 4'b0001 || pre[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL tmo_hold dut%0d c%0d: gnt=%b pre=%b want 0001/0",
                             i, c, gn[i], pre[i]);
                end
            end
        end
        step();
        for (int i = 2; i < 4; i++) begin
            total++;
            if (gn[i] !== 4'b0000 || pre[i] !== 1'b1) begin
                bad++;
                $display("FAIL tmo_gap dut%0d: gnt=%b pre=%b want 0000/1",
                         i, gn[i], pre[i]);
            end
        end
        step();
        for (int i = 2; i < 4; i++) begin
            total++;
            if (gn[i] !== 4'b0001 || gid[i] !== 2'd0 || pre[i] !== 1'b0) begin
                bad++;
                $display("FAIL tmo_regrant dut%0d: gnt=%b id=%0d pre=%b want 0001/0/0",
                         i, gn[i], gid[i], pre[i]);
            end
        end
        rq[2] = 4'b0000;
        rq[3] = 4'b0000;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        // last is 3 here, so without a reset 1001 would pick index 0
        rq[1] = 4'b0001;
        step();
        total++;
        if (gn[1] !== 4'b0001) begin
            bad++;
            $display("FAIL mid_pre_grant: gnt=%b want 0001", gn[1]);
        end
        step();
        rst = 1'b1;
        step();
        total++;
        if (gn[1] !== 4'b0000 || gid[1] !== 2'd0 ||
            bsy[1] !== 1'b0 || pre[1] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: gnt=%b id=%0d busy=%b pre=%b want 0",
                     gn[1], gid[1], bsy[1], pre[1]);
        end
        rst   = 1'b0;
        rq[1] = 4'b1001;
        step();
        total++;
        if (gn[1] !== 4'b1000 || gid[1] !== 2'd3) begin
            bad++;
            $display("FAIL last_reset: gnt=%b id=%0d want 1000/3",
                     gn[1], gid[1]);
        end
        rq[1] = 4'b0000;
        step();
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int i = 0; i < 4; i++) rq[i] = 4'b0000;
        test_reset();
        test_fixed();
        test_drop_timeout();
        test_round_robin();
        test_timeout_min();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb4_grant_ctrl.md
# arb4_grant_ctrl

Four-requester arbiter that shares one downstream resource (bus, port or datapath slot) between requesters `req[3:0]`. It selects a winner with a 4-bit priority encoder, which is either fixed-priority or rotating (round-robin). It holds the grant while the owner keeps requesting, forces release after a bounded hold time, and inserts one dead cycle between owners. It sits in front of the shared resource and drives its select lines from `gnt_id`.

## Interface
Parameters:
- `MODE`, default 1: selects the arbitration policy.
  - 0: fixed priority, `req[3]` highest down to `req[0]`.
  - 1: round-robin.
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner may hold the grant. Legal range is 2..255.

Ports:
- `clk` input 1: rising-edge clock; the single clock.
- `rst` input 1: synchronous, active-high reset.
- `req` input 4: request lines, level-sensitive, one per requester.
- `gnt` output 4: one-hot grant, registered; all-zero when no owner.
- `gnt_id` output 2: index of the current owner; 0 when `gnt` is 0.
- `busy` output 1: high exactly when `gnt` is non-zero.
- `preempt` output 1: one-cycle pulse in the RELEASE cycle when the release was forced by the hold timeout.

## Operation
Clock and reset:
- One clock; reset is synchronous and active-high.
- Reset values: `gnt`=0, `gnt_id`=0, `busy`=0, `preempt`=0.
- Internal reset values: state IDLE, `last`=0, `hold_cnt`=0.

States:
- IDLE
  - `gnt`=0.
  - If `req`≠0, encode a winner, load `gnt`/`gnt_id`, clear `hold_cnt` and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT
  - Owner `k` holds `gnt[k]`.
  - Each cycle `hold_cnt` increments.
  - If `req[k]`=0, go to RELEASE (normal release).
  - Else if `hold_cnt`=`MAX_HOLD`-1, go to RELEASE with `preempt` set (forced release).
  - Otherwise stay in GRANT.
- RELEASE
  - Exactly one cycle; `gnt`=0 and `busy`=0.
  - `last` is updated to `k` on entry.
  - Exit exactly like IDLE: grant immediately if `req`≠0, else go to IDLE.

Winner selection:
- MODE 0: the highest set index of `req` wins.
- MODE 1: search downward starting at (`last`−1) mod 4, wrapping 0→3; the first set bit wins.
  - The reset value `last`=0 makes the first search begin at index 3, so fixed and round-robin agree on the first grant.
- Forced-release handling: in MODE 1 a preempted owner still requesting is naturally deprioritised. In MODE 0 it may win again immediately; that is intended.

Width and counter rules:
- `hold_cnt` is 8 bits and saturates, never wraps.
- `gnt` is always one-hot or zero, never multi-hot.

## Timing
- Grant latency: `req` sampled at edge N in IDLE/RELEASE → `gnt` valid after edge N, i.e. one cycle.
- Release latency: the owner drops `req[k]` before edge M → `gnt[k]` stays high through cycle M, then the RELEASE cycle follows, then the next owner appears. Owner-to-owner gap is exactly 1 cycle.
- Forced release: `gnt[k]` is high for exactly `MAX_HOLD` cycles, then the RELEASE cycle with `preempt`=1.
- Requests changing on non-owner lines during GRANT are ignored until the next arbitration point.
- Reset asserted mid-GRANT: outputs are zero after that edge, with no RELEASE cycle and no `preempt`.
- Simultaneous owner drop and timeout in the same cycle: treat as a normal release, `preempt`=0.

## Structure
- Package `arb4_pkg`:
  - state enum {IDLE, GRANT, RELEASE}.
  - `MODE_FIXED`=0, `MODE_RR`=1.
  - `NREQ`=4.
- Sub-module `rot_prio_enc4`: combinational.
  - Inputs: `d[3:0]` and rotation `rot[1:0]`.
  - Output: winner index `out[1:0]` plus `valid`.
  - Function: rotate `d`, apply d[3]-highest priority encoding, un-rotate the index.
  - MODE 0 ties `rot` to 0; MODE 1 drives `rot` from `last`.
- The top module holds the FSM, `hold_cnt`, `last` and the output registers.

## Test plan
- Reset then idle: hold `rst` for 2 cycles with `req`=0000 → all outputs 0, state IDLE.
- Fixed priority, MODE 0: `req`=0110 → `gnt`=0100 and `gnt_id`=2 one cycle later. Drop `req[2]` → one RELEASE cycle with `gnt`=0, then `gnt`=0010.
- Round-robin, MODE 1: `req`=1111 held and `MAX_HOLD`=4 → grants go 3,2,1,0,3, each for 4 cycles separated by a 1-cycle gap, with `preempt`=1 in each gap.
- Timeout boundary, `MAX_HOLD`=2: single requester 0001 held → `gnt` high 2 cycles, gap with `preempt`=1, regrant to 0 in both modes.
- Simultaneous drop and timeout on the last hold cycle → RELEASE with `preempt`=0.
- Reset mid-operation: assert `rst` during GRANT → outputs 0 next cycle. Then `req`=1001 in MODE 1 → `gnt`=1000, confirming `last` was reset.
